pipeline_imem_port: RTL and testbench
=====================================

PIPELINE_IMEM_PORT -- requirements
Module: pipeline_imem_port

Interface
REQ-001 Parameter DEPTH, default 1024, instruction store size in 32-bit words; power of two.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reqValid  input  1  fetch unit presents a valid fetch address.
REQ-006 reqAddress  input  32  byte address of the requested instruction.
REQ-007 flush  input  1  cancel any in-flight request (branch/jump taken).
REQ-008 loadEnable  input  1  write one word into the instruction store.
REQ-009 loadAddress  input  32  byte address for the load write.
REQ-010 loadData  input  32  word written on loadEnable.
REQ-011 reqReady  output  1  port accepts a request this cycle.
REQ-012 respValid  output  1  instruction/respAddress valid this cycle (one-cycle pulse).
REQ-013 instruction  output  32  fetched word.
REQ-014 respAddress  output  32  byte address of the returned word.
REQ-015 stallOut  output  1  fetch unit must hold PC.
REQ-016 misaligned  output  1  returned request had reqAddress[1:0] != 0.
REQ-017 rangeError  output  1  returned request addressed beyond DEPTH*4 bytes.
REQ-018 haltSeen  output  1  sticky: a halt instruction has been returned.

Function
REQ-019 States IDLE, WAIT, RESP; reqReady SHALL be 1 only in IDLE with haltSeen=0 and flush=0.
REQ-020 Acceptance: reqValid && reqReady at an edge; port captures reqAddress, store word at index reqAddress[log2(DEPTH)+1:2], and error flags, then moves to WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-021 WAIT: down-counter loaded with LATENCY-2 at acceptance; RESP entered at the edge where counter reads 0.
REQ-022 RESP lasts exactly one cycle; respValid = (state==RESP) && !flush; next state IDLE.
REQ-023 respValid SHALL be high in exactly the LATENCY-th cycle after the accepting cycle; no back-to-back accept, throughput one request per LATENCY+1 cycles.
REQ-024 instruction, respAddress, misaligned, rangeError hold captured values while respValid=1; all zero otherwise.
REQ-025 Misaligned request: word fetched with address bits [1:0] ignored; misaligned=1 with respValid.
REQ-026 Out-of-range request (reqAddress >= DEPTH*4): instruction returned as 32'h0, rangeError=1 with respValid.
REQ-027 stallOut = (state != IDLE) || (reqValid && !reqReady).
REQ-028 flush in WAIT: next state IDLE, no respValid for that request; flush in RESP suppresses respValid; flush in IDLE blocks acceptance.
REQ-029 loadEnable writes loadData at loadAddress index every edge regardless of state; out-of-range load addresses ignored.
REQ-030 Load and accept to the same word in one cycle: captured word is the old contents.
REQ-031 haltSeen sets at edge following respValid && instruction[11:0]==12'h300; clears only on reset.

Reset
REQ-032 reset SHALL force state IDLE, counter 0, haltSeen 0, respValid 0, all captured registers 0; reset mid-request drops it with no response.
REQ-033 reset SHALL NOT clear the instruction store.

Verification
REQ-034 LATENCY=2, store[3]=32'h20010005; request 0x0C accepted cycle 0 -> respValid only in cycle 2, instruction 0x20010005, respAddress 0x0C, stallOut 1 in cycles 1-2.
REQ-035 Request 0x0E -> word at index 3 returned with misaligned=1; request 0x00001000 (DEPTH=1024) -> instruction 0, rangeError=1.
REQ-036 Flush asserted cycle 1 after accept at cycle 0 -> no respValid, reqReady 1 in cycle 2, next request served normally.
REQ-037 Store word 32'h00000300 at 0x10 and fetch it -> haltSeen 1 next cycle, reqReady stays 0 until reset.
REQ-038 loadEnable writing 0xDEADBEEF to 0x20 while 0x20 accepted -> response carries old word; re-fetch returns 0xDEADBEEF.
REQ-039 reset asserted in WAIT -> no respValid, all outputs 0 next cycle; store contents preserved on subsequent fetch.

Source files
------------

// File: rtl/pipeline_imem_port.sv
// Instruction memory port for a fetch unit: one request in flight, fixed LATENCY-cycle
// response, flush/halt handling, and a side-band load path into the instruction store.
module pipeline_imem_port #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    input  logic [31:0] reqAddress,
    input  logic        flush,
    input  logic        loadEnable,
    input  logic [31:0] loadAddress,
    input  logic [31:0] loadData,
    output logic        reqReady,
    output logic        respValid,
    output logic [31:0] instruction,
    output logic [31:0] respAddress,
    output logic        stallOut,
    output logic        misaligned,
    output logic        rangeError,
    output logic        haltSeen
);

    localparam int AW = $clog2(DEPTH);
    localparam int CNT_INIT_I = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam logic [1:0] CNT_INIT = CNT_INIT_I[1:0];

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
        logic        misaligned;
        logic        rangeError;
    } respT;

    logic [31:0] store [DEPTH];

    stateT       state, stateNext;
    logic [1:0]  count, countNext;
    respT        captured;
    logic        haltReg;
    logic        accept;
    logic        reqInRange, loadInRange;
    logic [AW-1:0] reqIndex, loadIndex;

    assign reqInRange  = (reqAddress  >> (AW + 2)) == 32'd0;
    assign loadInRange = (loadAddress >> (AW + 2)) == 32'd0;
    assign reqIndex    = reqAddress[AW+1:2];
    assign loadIndex   = loadAddress[AW+1:2];

    assign reqReady  = (state == IDLE) && !haltReg && !flush;
    assign accept    = reqValid && reqReady;
    assign stallOut  = (state != IDLE) || (reqValid && !reqReady);
    assign respValid = (state == RESP) && !flush;
    assign haltSeen  = haltReg;

    assign instruction = respValid ? captured.word       : 32'd0;
    assign respAddress = respValid ? captured.addr       : 32'd0;
    assign misaligned  = respValid && captured.misaligned;
    assign rangeError  = respValid && captured.rangeError;

    // Store is never reset; a same-cycle load and accept capture the pre-write word.
    always_ff @(posedge clk) begin
        if (loadEnable && loadInRange)
            store[loadIndex] <= loadData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 2'd0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    always_comb begin
        stateNext = state;
        countNext = count;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        stateNext = RESP;
                    end else begin
                        stateNext = WAIT;
                        countNext = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (flush)
                    stateNext = IDLE;
                else if (count == 2'd0)
                    stateNext = RESP;
                else
                    countNext = count - 2'd1;
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            captured <= '0;
            haltReg  <= 1'b0;
        end else begin
            if (accept) begin
                captured.word       <= reqInRange ? store[reqIndex] : 32'd0;
                captured.addr       <= reqAddress;
                captured.misaligned <= |reqAddress[1:0];
                captured.rangeError <= !reqInRange;
            end
            if (respValid && captured.word[11:0] == 12'h300)
                haltReg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_imem_port.sv
// Scoreboard bench for pipeline_imem_port: a cycle-level reference model queues expected
// responses at acceptance; a negedge monitor pops and compares whenever respValid is seen.
module tb_pipeline_imem_port;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset, reqValid, flush, loadEnable;
    logic [31:0] reqAddress, loadAddress, loadData;
    logic        reqReady, respValid, stallOut, misaligned, rangeError, haltSeen;
    logic [31:0] instruction, respAddress;

    always #5 clk = ~clk;

    pipeline_imem_port #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .reqValid(reqValid), .reqAddress(reqAddress),
        .flush(flush), .loadEnable(loadEnable), .loadAddress(loadAddress),
        .loadData(loadData), .reqReady(reqReady), .respValid(respValid),
        .instruction(instruction), .respAddress(respAddress), .stallOut(stallOut),
        .misaligned(misaligned), .rangeError(rangeError), .haltSeen(haltSeen)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        bit          mis;
        bit          rng;
        int          cycle;
    } expT;

    expT         sb[$];
    logic [31:0] modelMem [DEPTH];
    bit          inflight = 0, haltM = 0, checkOn = 0;
    int          respCycle = 0, cyc = 0;
    logic [31:0] inflightWord = 0;
    int          checks = 0, errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: one outstanding fetch, answered LAT cycles after the accepting cycle.
    initial forever begin
        bit  acc;
        expT e;
        @(posedge clk);
        if (reset) begin
            inflight = 0;
            haltM    = 0;
            sb.delete();
            checkOn  = 1;
        end else begin
            acc = reqValid && !inflight && !haltM && !flush;
            if (inflight) begin
                if (cyc == respCycle && !flush && inflightWord[11:0] == 12'h300) haltM = 1;
                if (flush) sb.delete();
                if (flush || cyc == respCycle) inflight = 0;
            end
            if (acc) begin
                e.addr  = reqAddress;
                e.rng   = !(reqAddress < DEPTH * 4);
                e.word  = e.rng ? 32'd0 : modelMem[reqAddress >> 2];
                e.mis   = (reqAddress % 4) != 0;
                e.cycle = cyc + LAT;
                sb.push_back(e);
                inflight     = 1;
                respCycle    = e.cycle;
                inflightWord = e.word;
            end
        end
        if (loadEnable && loadAddress < DEPTH * 4) modelMem[loadAddress >> 2] = loadData;
        cyc++;
    end

    initial forever begin
        bit  expReady;
        expT e;
        @(negedge clk);
        if (checkOn) begin
            expReady = !inflight && !haltM && !flush;
            chk("reqReady", 32'(reqReady), 32'(expReady));
            chk("stallOut", 32'(stallOut), 32'(inflight || (reqValid && !expReady)));
            chk("haltSeen", 32'(haltSeen), 32'(haltM));
            if (respValid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpectedResp cycle %0d: got addr %h expected no response", cyc, respAddress);
                end else begin
                    e = sb.pop_front();
                    chk("respCycle",   cyc,                  e.cycle);
                    chk("instruction", instruction,          e.word);
                    chk("respAddress", respAddress,          e.addr);
                    chk("misaligned",  32'(misaligned),      32'(e.mis));
                    chk("rangeError",  32'(rangeError),      32'(e.rng));
                end
            end else begin
                chk("idleZero", instruction | respAddress | {30'd0, misaligned, rangeError}, 32'd0);
                if (sb.size() > 0 && (sb[0].cycle < cyc || (sb[0].cycle == cyc && !flush))) begin
                    checks++; errors++;
                    $display("FAIL missingResp cycle %0d: got no respValid expected addr %h", cyc, sb[0].addr);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive(bit rv, logic [31:0] ra, bit fl, bit le, logic [31:0] la,
                         logic [31:0] ld, bit rs);
        reqValid = rv; reqAddress = ra; flush = fl;
        loadEnable = le; loadAddress = la; loadData = ld; reset = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
    endtask

    initial begin
        logic [31:0] d, a, la;
        int          r;
        drive(0, 32'd0, 0, 0, 32'd0, 32'd0, 1);
        drive(0, 32'd0, 0, 0, 32'd0, 32'd0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            if (d[11:0] == 12'h300) d[0] = 1'b1;
            if (i == 3) d = 32'h20010005;
            drive(0, 32'd0, 0, 1, 32'(i * 4), d, 0);
        end
        idle(2);
        // basic, misaligned, out-of-range fetches
        drive(1, 32'h0000000C, 0, 0, 0, 0, 0); idle(3);
        drive(1, 32'h0000000E, 0, 0, 0, 0, 0); idle(3);
        drive(1, 32'h00001000, 0, 0, 0, 0, 0); idle(3);
        // flush while waiting, then a normal request right after
        drive(1, 32'h00000010, 0, 0, 0, 0, 0);
        drive(0, 32'd0,        1, 0, 0, 0, 0);
        drive(1, 32'h00000014, 0, 0, 0, 0, 0); idle(3);
        // load and accept colliding on one word
        drive(1, 32'h00000020, 0, 1, 32'h20, 32'hDEADBEEF, 0); idle(3);
        drive(1, 32'h00000020, 0, 0, 0, 0, 0); idle(3);
        // reset while waiting; store survives
        drive(1, 32'h00000024, 0, 0, 0, 0, 0);
        drive(0, 32'd0,        0, 0, 0, 0, 1); idle(3);
        drive(1, 32'h00000024, 0, 0, 0, 0, 0); idle(3);
        // halt word fetched; requests then stay blocked until reset
        drive(0, 32'd0, 0, 1, 32'h10, 32'h00000300, 0);
        drive(1, 32'h00000010, 0, 0, 0, 0, 0);
        repeat (6) drive(1, 32'h00000004, 0, 0, 0, 0, 0);
        drive(0, 32'd0, 0, 0, 0, 0, 1);
        idle(2);
        repeat (4000) begin
            r = $urandom_range(0, 19);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(DEPTH * 4 + $urandom_range(0, 15));
            else             a = 32'($urandom_range(0, DEPTH - 1) * 4 + (r == 2 ? $urandom_range(1, 3) : 0));
            la = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4);
            d  = $urandom;
            if ($urandom_range(0, 49) == 0) d[11:0] = 12'h300;
            else if (d[11:0] == 12'h300)    d[0] = 1'b1;
            drive($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) == 0, la, d, $urandom_range(0, 99) == 0);
        end
        idle(LAT + 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
